// File: rtl/text_cell_fetcher.sv
// Text-mode cell fetcher: walks the 80x25 character buffer in step with the
// sync generator, fetches one {attribute, character} word per 8-pixel cell
// and presents glyph code, glyph row/column, colour indices and the cursor
// flag to the font/colour lookup stage, LATENCY pixel clocks after x/y/active.
module text_cell_fetcher #(
  parameter int LATENCY = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        active,
  input  logic        frame_start,
  input  logic        cursor_enable,
  input  logic [10:0] cursor_pos,
  input  logic        blink_enable,
  output logic        vram_access,
  output logic [10:0] vram_addr,
  input  logic        vram_ack,
  input  logic [15:0] vram_data,
  output logic [7:0]  glyph,
  output logic [2:0]  glyph_row,
  output logic [2:0]  glyph_col,
  output logic [3:0]  foreground,
  output logic [3:0]  background,
  output logic        render_cursor,
  output logic        pixel_valid,
  output logic        underrun
);

  // The last of the LATENCY stages is the output register itself.
  localparam int STAGES = LATENCY - 1;
  localparam logic [15:0] BLANK_CELL = 16'h0720;

  typedef struct packed {
    logic       act;
    logic [9:0] px;
    logic [9:0] py;
  } pix_t;

  function automatic logic [10:0] cell_of(input logic [9:0] px, input logic [9:0] py);
    logic [10:0] row;
    logic [10:0] col;
    row = {6'd0, py[8:4]};
    col = {4'd0, px[9:3]};
    return (row << 6) + (row << 4) + col;
  endfunction

  pix_t        dly [STAGES];
  pix_t        tail;
  logic        slot;
  logic [10:0] slot_idx;
  logic [10:0] tail_idx;
  logic        transfer;

  // VRAM handshake: vram_access/vram_addr rise together and are held
  // unchanged until the single-cycle vram_ack (data valid in that cycle);
  // access drops on the following cycle. A request is never withdrawn.
  logic        pending;
  logic [3:0]  age;
  logic        ack_hit;
  logic        timely;
  logic        late;
  logic [15:0] next_cell;
  logic        next_ok;
  logic [15:0] disp_cell;
  logic [15:0] incoming;
  logic [15:0] cur_cell;
  logic [7:0]  attr;
  logic [3:0]  fg_next;
  logic [3:0]  bg_next;
  logic [5:0]  frame_count;

  assign slot     = active && (x[2:0] == 3'd0);
  assign slot_idx = cell_of(x, y);
  assign tail     = dly[STAGES-1];
  assign tail_idx = cell_of(tail.px, tail.py);
  assign transfer = tail.act && (tail.px[2:0] == 3'd0);

  // age counts cycles since the owning slot: 1..7 is on time, 8 is late.
  assign ack_hit  = vram_ack && pending;
  assign timely   = ack_hit && (age <= 4'd7);
  assign late     = ack_hit && !timely;
  assign vram_access = pending;

  // A deadline ack arrives in the transfer cycle itself, so bypass it.
  assign incoming = timely ? vram_data : (next_ok ? next_cell : BLANK_CELL);

  // Pixel position delay line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) dly[i] <= '0;
    end else begin
      dly[0] <= {active, x, y};
      for (int i = 1; i < STAGES; i++) dly[i] <= dly[i-1];
    end
  end

  // Fetch request issue, ack tracking and next-cell register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending   <= 1'b0;
      vram_addr <= '0;
      age       <= '0;
      next_cell <= '0;
      next_ok   <= 1'b0;
    end else begin
      if (ack_hit) pending <= 1'b0;
      else if (pending && age < 4'd8) age <= age + 4'd1;
      if (timely) begin
        next_cell <= vram_data;
        next_ok   <= 1'b1;
      end
      // A slot always starts a fresh cell; if a request is still out the
      // slot is skipped and the cell stays blank.
      if (slot) begin
        next_ok <= 1'b0;
        if (!pending) begin
          pending   <= 1'b1;
          vram_addr <= slot_idx;
          age       <= 4'd1;
        end
      end
    end
  end

  // Colour selection from the cell shown at this pixel.
  always_comb begin
    cur_cell = transfer ? incoming : disp_cell;
    attr     = cur_cell[15:8];
    fg_next  = attr[3:0];
    bg_next  = attr[7:4];
    if (blink_enable && attr[7]) begin
      bg_next = {1'b0, attr[6:4]};
      if (frame_count[5]) fg_next = bg_next;
    end
  end

  // Display register, frame counter, underrun flag and output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_cell     <= '0;
      frame_count   <= '0;
      underrun      <= 1'b0;
      glyph         <= '0;
      glyph_row     <= '0;
      glyph_col     <= '0;
      foreground    <= '0;
      background    <= '0;
      render_cursor <= 1'b0;
      pixel_valid   <= 1'b0;
    end else begin
      if (transfer) disp_cell <= incoming;
      if (frame_start) frame_count <= frame_count + 6'd1;
      if (late || (transfer && !timely && !next_ok)) underrun <= 1'b1;
      pixel_valid <= tail.act;
      if (tail.act) begin
        glyph         <= cur_cell[7:0];
        glyph_row     <= tail.py[3:1];
        glyph_col     <= tail.px[2:0];
        foreground    <= fg_next;
        background    <= bg_next;
        render_cursor <= cursor_enable && (tail_idx == cursor_pos) &&
                         (tail.py[3:2] == 2'b11) && !frame_count[4];
      end else begin
        glyph         <= '0;
        glyph_row     <= '0;
        glyph_col     <= '0;
        foreground    <= '0;
        background    <= '0;
        render_cursor <= 1'b0;
      end
    end
  end

endmodule
